// File: rtl/divider.sv
// ----------------------------------------------------------------------------
// divider
//   Multi-cycle restoring integer divider. It produces one quotient bit per
//   clock from a shared WIDTH+1-bit trial subtraction. Signed operands are
//   reduced to magnitudes on entry, and the result signs are applied in a
//   final fix-up cycle.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   div_begin  start request, sampled only while busy=0
//   div_signed 1 = two's-complement operands, 0 = unsigned
//   div_op1    dividend
//   div_op2    divisor
//   busy       high while an operation occupies the RUN or FIX state
//   div_end    one-cycle pulse when quotient/remainder are new
//   quotient   registered quotient, held until the next completion
//   remainder  registered remainder, held until the next completion
// ----------------------------------------------------------------------------
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_begin,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_op1,
    input  logic [WIDTH-1:0] div_op2,
    output logic             busy,
    output logic             div_end,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;     // partial remainder
    logic [WIDTH-1:0] quo_r;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dsr;       // |divisor|
    logic [WIDTH-1:0] op1_save;  // raw dividend, returned on divide-by-zero
    logic             div_zero;
    logic             neg_q;
    logic             neg_r;

    // Operand magnitudes. The most negative value maps onto itself, which
    // still reads correctly as an unsigned magnitude.
    logic             op1_neg;
    logic             op2_neg;
    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;

    always_comb begin
        op1_neg = div_signed & div_op1[WIDTH-1];
        op2_neg = div_signed & div_op2[WIDTH-1];
        op1_abs = op1_neg ? (~div_op1 + 1'b1) : div_op1;
        op2_abs = op2_neg ? (~div_op2 + 1'b1) : div_op2;
    end

    // One restoring step. Since rem_r < dsr, the shifted value is below
    // 2*dsr, so the WIDTH+1-bit difference cannot wrap. Its top bit is
    // therefore a reliable sign.
    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        r_sh  = {rem_r, quo_r[WIDTH-1]};
        trial = r_sh - {1'b0, dsr};
    end

    logic accept;
    assign accept = div_begin && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            dsr       <= '0;
            op1_save  <= '0;
            div_zero  <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            busy      <= 1'b0;
            div_end   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            div_end <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        rem_r    <= '0;
                        quo_r    <= op1_abs;
                        dsr      <= op2_abs;
                        op1_save <= div_op1;
                        div_zero <= (div_op2 == '0);
                        neg_q    <= op1_neg ^ op2_neg;
                        neg_r    <= op1_neg;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        // A zero divisor skips the iterations entirely.
                        state    <= (div_op2 == '0) ? S_FIX : S_RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (!trial[WIDTH]) rem_r <= trial[WIDTH-1:0];
                    else               rem_r <= r_sh[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (div_zero) begin
                        quotient  <= '1;
                        remainder <= op1_save;
                    end else begin
                        quotient  <= neg_q ? (~quo_r + 1'b1) : quo_r;
                        remainder <= neg_r ? (~rem_r + 1'b1) : rem_r;
                    end
                    busy    <= 1'b0;
                    div_end <= 1'b1;
                    state   <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// ----------------------------------------------------------------------------
// tb_divider
//   Self-checking bench for divider (WIDTH=32). It checks the directed cases
//   and randomized operands against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_divider;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;
    localparam logic [W-1:0] MAXV = 32'h7FFF_FFFF;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         div_begin = 1'b0;
    logic         div_signed = 1'b0;
    logic [W-1:0] div_op1 = '0;
    logic [W-1:0] div_op2 = '0;
    logic         busy;
    logic         div_end;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_chk  = 0;
    int n_fail = 0;

    divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_begin  (div_begin),
        .div_signed (div_signed),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
        .busy       (busy),
        .div_end    (div_end),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic division with the documented special cases.
    function automatic void model(input logic s, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == MINV && b == '1) begin
            q = MINV;
            r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    function automatic int exp_lat(input logic [W-1:0] b);
        return (b == 0) ? 1 : W + 1;
    endfunction

    // Driver: it issues one op, scrambles the operand inputs after sampling,
    // waits for div_end (bounded), and reports the results and latency.
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output int lat, output logic busy_ok);
        div_signed = s;
        div_op1    = a;
        div_op2    = b;
        div_begin  = 1'b1;
        @(posedge clk); #1;
        div_begin  = 1'b0;
        div_op1    = $urandom;
        div_op2    = $urandom;
        div_signed = 1'($urandom);
        busy_ok = busy;
        lat = 0;
        q = 'x;
        r = 'x;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            lat++;
            if (div_end) begin
                q = quotient;
                r = remainder;
                if (busy) busy_ok = 1'b0;
                break;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if (busy !== 1'b0 || div_end !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b end=%b q=%h r=%h, want 0 0 0 0",
                     busy, div_end, quotient, remainder);
        end
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0 || div_end !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b end=%b, want 0 0", busy, div_end);
        end
    endtask

    // A directed op checked for the result, latency and busy profile.
    task automatic check_op(input string name, input logic s,
                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r, eq, er;
        int lat;
        logic bok;
        model(s, a, b, eq, er);
        run_op(s, a, b, q, r, lat, bok);
        n_chk++;
        if (q !== eq || r !== er || lat != exp_lat(b) || !bok) begin
            n_fail++;
            $display("FAIL %s: q=%h r=%h lat=%0d busy_ok=%b, want q=%h r=%h lat=%0d busy_ok=1",
                     name, q, r, lat, bok, eq, er, exp_lat(b));
        end
    endtask

    task automatic test_basic();
        check_op("u_100_7", 1'b0, 32'd100, 32'd7);
        // div_end is a single-cycle pulse; results hold while idle.
        @(posedge clk); #1;
        n_chk++;
        if (div_end !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
            n_fail++;
            $display("FAIL end_pulse_hold: end=%b q=%h r=%h, want 0 e 2", div_end, quotient, remainder);
        end
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: q=%h r=%h busy=%b, want e 2 0", quotient, remainder, busy);
        end
    endtask

    task automatic test_signed();
        check_op("s_m7_2",  1'b1, 32'hFFFF_FFF9, 32'd2);
        check_op("s_7_m2",  1'b1, 32'd7, 32'hFFFF_FFFE);
        check_op("u_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        check_op("s_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
    endtask

    task automatic test_div_zero();
        check_op("u_divzero", 1'b0, 32'h1234_5678, 32'd0);
        check_op("s_divzero", 1'b1, 32'h1234_5678, 32'd0);
        check_op("s_neg_divzero", 1'b1, 32'h8765_4321, 32'd0);
    endtask

    task automatic test_boundary();
        check_op("s_min_m1", 1'b1, MINV, 32'hFFFF_FFFF);
        check_op("u_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1);
        check_op("s_min_1",  1'b1, MINV, 32'd1);
        check_op("s_max_min", 1'b1, MAXV, MINV);
        check_op("u_small_big", 1'b0, 32'd5, 32'hFFFF_FFFF);
        check_op("u_zero_num", 1'b0, 32'd0, 32'd9);
    endtask

    // A begin request during an op is ignored; then a begin in the DONE cycle
    // starts the next op immediately.
    task automatic test_back_to_back();
        logic [W-1:0] q, r;
        int lat;
        logic bok;
        int t;
        div_signed = 1'b0;
        div_op1    = 32'd1_000_003;
        div_op2    = 32'd17;
        div_begin  = 1'b1;
        @(posedge clk); #1;
        div_begin = 1'b0;
        t = 0;
        q = 'x;
        r = 'x;
        for (int i = 0; i < 80; i++) begin
            if (t == 9) begin
                div_begin  = 1'b1;
                div_signed = 1'b1;
                div_op1    = 32'hDEAD_BEEF;
                div_op2    = 32'd3;
            end else begin
                div_begin = 1'b0;
            end
            @(posedge clk); #1;
            t++;
            if (div_end) begin
                q = quotient;
                r = remainder;
                break;
            end
        end
        div_begin = 1'b0;
        n_chk++;
        if (q !== 32'd58823 || r !== 32'd12 || t != W + 1) begin
            n_fail++;
            $display("FAIL ignore_begin: q=%h r=%h lat=%0d, want %h %h %0d",
                     q, r, t, 32'd58823, 32'd12, W + 1);
        end
        // Still in the DONE cycle: issue the next op.
        run_op(1'b1, 32'hFFFF_FC18, 32'd10, q, r, lat, bok);
        n_chk++;
        if (q !== 32'hFFFF_FF9C || r !== 32'd0 || lat != W + 1 || !bok) begin
            n_fail++;
            $display("FAIL back_to_back: q=%h r=%h lat=%0d busy_ok=%b, want ffffff9c 0 %0d 1",
                     q, r, lat, bok, W + 1);
        end
        // A divide-by-zero op, also back-to-back.
        run_op(1'b0, 32'd77, 32'd0, q, r, lat, bok);
        n_chk++;
        if (q !== '1 || r !== 32'd77 || lat != 1) begin
            n_fail++;
            $display("FAIL b2b_divzero: q=%h r=%h lat=%0d, want ffffffff 4d 1", q, r, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r;
        int lat;
        logic bok;
        logic seen;
        div_signed = 1'b0;
        div_op1    = 32'd5000;
        div_op2    = 32'd3;
        div_begin  = 1'b1;
        @(posedge clk); #1;
        div_begin = 1'b0;
        repeat (14) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || div_end !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b end=%b q=%h r=%h, want 0 0 0 0",
                     busy, div_end, quotient, remainder);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (div_end || busy) seen = 1'b1;
        end
        n_chk++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_abort: div_end/busy seen after release, want none");
        end
        run_op(1'b0, 32'd1000, 32'd10, q, r, lat, bok);
        n_chk++;
        if (q !== 32'd100 || r !== 32'd0 || lat != W + 1 || !bok) begin
            n_fail++;
            $display("FAIL post_reset_op: q=%h r=%h lat=%0d, want 64 0 %0d", q, r, lat, W + 1);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return MINV;
            4: return MAXV;
            5: return 32'($urandom_range(1, 255));
            6: return -32'($urandom_range(1, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic s, bok;
        int lat;
        for (int i = 0; i < 1200; i++) begin
            s = 1'($urandom);
            a = pick();
            b = pick();
            model(s, a, b, eq, er);
            run_op(s, a, b, q, r, lat, bok);
            n_chk++;
            if (q !== eq || r !== er || lat != exp_lat(b) || !bok) begin
                n_fail++;
                $display("FAIL random[%0d] s=%b %h/%h: q=%h r=%h lat=%0d busy_ok=%b, want q=%h r=%h lat=%0d",
                         i, s, a, b, q, r, lat, bok, eq, er, exp_lat(b));
            end
            // Mix back-to-back and idle-gap issue.
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
